clock_div_n: RTL and testbench

- Programmable integer clock divider and clock-enable generator. Parametrised successor to the fixed divide-by-2 divider.
- Produces a registered divided clock `outClock`, plus single-cycle strobes `outTick` and `outRise` in the source domain for use as clock enables.
- Sits next to the VGA timing logic. Derives pixel, audio and slow-tick rates from the 50 MHz board clock.
- Divide ratio is run-time selectable. Ratio changes take effect only at a period boundary, so no runt pulses are produced.

---
 rtl/clock_div_n_if.sv | 44 ++++
 rtl/clock_div_n.sv | 89 ++++++++
 tb/tb_clock_div_n.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/clock_div_n_if.sv
// -----------------------------------------------------------------------------
// clock_div_n_if
// Control/status bundle for the programmable clock divider.
//   inEnable   : run (1) / freeze (0) the divider
//   inSync     : synchronous phase restart
//   inDivide   : requested divide ratio N (0 and 1 are treated as 2)
//   outClock   : registered divided clock
//   outTick    : one-cycle strobe at the end of each period
//   outRise    : one-cycle strobe when outClock goes 0->1
//   outPeriod  : ratio currently in effect
// The master modport belongs to the controlling logic, the slave modport to
// the divider itself.
// -----------------------------------------------------------------------------
interface clock_div_n_if #(
  parameter int CNT_W = 16
);
  logic             inEnable;
  logic             inSync;
  logic [CNT_W-1:0] inDivide;
  logic             outClock;
  logic             outTick;
  logic             outRise;
  logic [CNT_W-1:0] outPeriod;

  modport master (
    output inEnable,
    output inSync,
    output inDivide,
    input  outClock,
    input  outTick,
    input  outRise,
    input  outPeriod
  );

  modport slave (
    input  inEnable,
    input  inSync,
    input  inDivide,
    output outClock,
    output outTick,
    output outRise,
    output outPeriod
  );
endinterface

// File: rtl/clock_div_n.sv
// -----------------------------------------------------------------------------
// clock_div_n
// Programmable integer clock divider / clock-enable generator.
//   clock50MHz : source clock, all logic on its rising edge
//   inReset    : synchronous active-high reset
//   bus        : clock_div_n_if slave (enable, sync, ratio in; divided clock,
//                end-of-period tick, rising strobe and active ratio out)
// The divided clock is high for floor(N/2) and low for ceil(N/2) cycles of
// each N-cycle period. A new ratio is only picked up on the wrap edge, so the
// running period always completes without a runt phase. Every output comes
// straight from a flop.
// -----------------------------------------------------------------------------
module clock_div_n #(
  parameter int CNT_W = 16
) (
  input  logic          clock50MHz,
  input  logic          inReset,
  clock_div_n_if.slave  bus
);

  // Ratios below 2 cannot form a high and a low phase, so they become 2.
  function automatic logic [CNT_W-1:0] clampRatio(input logic [CNT_W-1:0] ratio);
    if (ratio < CNT_W'(2)) begin
      return CNT_W'(2);
    end else begin
      return ratio;
    end
  endfunction

  logic [CNT_W-1:0] cntReg;
  logic [CNT_W-1:0] perReg;
  logic             clockReg;
  logic             tickReg;
  logic             riseReg;

  logic [CNT_W-1:0] cntNext;
  logic             wrapNext;
  logic             clockNext;

  // Next counter value and next divided-clock level for an enabled edge.
  always_comb begin
    cntNext   = cntReg + CNT_W'(1);
    wrapNext  = 1'b0;
    clockNext = 1'b0;
    if (cntReg == (perReg - CNT_W'(1))) begin
      cntNext  = CNT_W'(0);
      wrapNext = 1'b1;
    end else begin
      wrapNext = 1'b0;
    end
    // High phase is the last floor(per/2) counts of the period; uses the
    // ratio of the period that is still running.
    clockNext = (cntNext >= (perReg - (perReg >> 1)));
  end

  // Divider state: reset/sync restart, enabled advance, or freeze.
  always_ff @(posedge clock50MHz) begin
    if (inReset || bus.inSync) begin
      cntReg   <= CNT_W'(0);
      perReg   <= clampRatio(bus.inDivide);
      clockReg <= 1'b0;
      tickReg  <= 1'b0;
      riseReg  <= 1'b0;
    end else if (bus.inEnable) begin
      cntReg   <= cntNext;
      clockReg <= clockNext;
      tickReg  <= (cntNext == CNT_W'(0));
      riseReg  <= clockNext & ~clockReg;
      if (wrapNext) begin
        perReg <= clampRatio(bus.inDivide);
      end else begin
        perReg <= perReg;
      end
    end else begin
      // Frozen: phase and ratio hold, strobes are suppressed.
      cntReg   <= cntReg;
      perReg   <= perReg;
      clockReg <= clockReg;
      tickReg  <= 1'b0;
      riseReg  <= 1'b0;
    end
  end

  assign bus.outClock  = clockReg;
  assign bus.outTick   = tickReg;
  assign bus.outRise   = riseReg;
  assign bus.outPeriod = perReg;

endmodule

// File: tb/tb_clock_div_n.sv
// -----------------------------------------------------------------------------
// tb_clock_div_n
// Directed bench for clock_div_n. Output triples are written as
// {outClock, outTick, outRise}, sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_clock_div_n;

  logic clock50MHz;
  logic resetA;
  logic resetB;

  int checkCount;
  int errorCount;

  clock_div_n_if #(.CNT_W(16)) busA ();
  clock_div_n_if #(.CNT_W(4))  busB ();

  clock_div_n #(.CNT_W(16)) dutA (
    .clock50MHz (clock50MHz),
    .inReset    (resetA),
    .bus        (busA)
  );

  clock_div_n #(.CNT_W(4)) dutB (
    .clock50MHz (clock50MHz),
    .inReset    (resetB),
    .bus        (busB)
  );

  // 50 MHz source clock.
  initial clock50MHz = 1'b0;
  always #10 clock50MHz = ~clock50MHz;

  // Expected per-period triples.
  logic [2:0] patN2 [2] = '{3'b101, 3'b010};
  logic [2:0] patN5 [5] = '{3'b000, 3'b000, 3'b101, 3'b100, 3'b010};
  logic [2:0] patN7 [7] = '{3'b000, 3'b000, 3'b000, 3'b101, 3'b100, 3'b100, 3'b010};

  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    checkCount = checkCount + 1;
    if (observed !== expected) begin
      errorCount = errorCount + 1;
      $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clock50MHz);
    #1;
  endtask

  task automatic stepExpect(input string tag, input logic [2:0] exp);
    stepCycle();
    checkValue(tag, {29'd0, busA.outClock, busA.outTick, busA.outRise}, {29'd0, exp});
  endtask

  task automatic resetWith(input logic [15:0] divide, input logic [15:0] expPer);
    busA.inDivide = divide;
    busA.inEnable = 1'b1;
    busA.inSync   = 1'b0;
    resetA = 1'b1;
    stepCycle();
    stepCycle();
    checkValue("reset_outs", {29'd0, busA.outClock, busA.outTick, busA.outRise}, 32'd0);
    checkValue("reset_period", {16'd0, busA.outPeriod}, {16'd0, expPer});
    resetA = 1'b0;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    resetA = 1'b1;
    resetB = 1'b1;
    busA.inEnable = 1'b1;
    busA.inSync   = 1'b0;
    busA.inDivide = 16'd2;
    busB.inEnable = 1'b1;
    busB.inSync   = 1'b0;
    busB.inDivide = 4'd15;
    #1;

    // Legacy divide-by-2 sequence.
    resetWith(16'd2, 16'd2);
    for (int i = 0; i < 8; i++) stepExpect("legacy_n2", patN2[i % 2]);

    // Ratios 0 and 1 clamp to 2.
    resetWith(16'd0, 16'd2);
    for (int i = 0; i < 4; i++) stepExpect("clamp_0", patN2[i % 2]);
    checkValue("clamp_0_period", {16'd0, busA.outPeriod}, 32'd2);
    resetWith(16'd1, 16'd2);
    for (int i = 0; i < 4; i++) stepExpect("clamp_1", patN2[i % 2]);

    // Odd ratio, 20 periods.
    resetWith(16'd5, 16'd5);
    for (int p = 0; p < 20; p++) begin
      for (int i = 0; i < 5; i++) stepExpect("odd_n5", patN5[i]);
    end

    // Ratio change 4 -> 7 requested at cnt=1.
    resetWith(16'd4, 16'd4);
    stepExpect("chg_n4_e1", 3'b000);
    busA.inDivide = 16'd7;
    stepExpect("chg_n4_e2", 3'b101);
    stepExpect("chg_n4_e3", 3'b100);
    checkValue("chg_period_old", {16'd0, busA.outPeriod}, 32'd4);
    stepExpect("chg_n4_e4", 3'b010);
    checkValue("chg_period_new", {16'd0, busA.outPeriod}, 32'd7);
    for (int i = 0; i < 7; i++) stepExpect("chg_n7", patN7[i]);

    // Enable freeze with N=6: low phase at cnt=2, then high phase at cnt=4.
    resetWith(16'd6, 16'd6);
    stepExpect("en_e1", 3'b000);
    stepExpect("en_e2", 3'b000);
    busA.inEnable = 1'b0;
    for (int i = 0; i < 3; i++) stepExpect("en_freeze_low", 3'b000);
    busA.inEnable = 1'b1;
    stepExpect("en_e3", 3'b101);
    stepExpect("en_e4", 3'b100);
    busA.inEnable = 1'b0;
    for (int i = 0; i < 2; i++) stepExpect("en_freeze_high", 3'b100);
    busA.inEnable = 1'b1;
    stepExpect("en_e5", 3'b100);
    stepExpect("en_e6", 3'b010);

    // Sync pulse at cnt=4, then level sync.
    stepExpect("sync_e1", 3'b000);
    stepExpect("sync_e2", 3'b000);
    stepExpect("sync_e3", 3'b101);
    stepExpect("sync_e4", 3'b100);
    busA.inSync = 1'b1;
    stepExpect("sync_pulse", 3'b000);
    busA.inSync = 1'b0;
    stepExpect("sync_after_e1", 3'b000);
    stepExpect("sync_after_e2", 3'b000);
    stepExpect("sync_after_e3", 3'b101);
    busA.inSync = 1'b1;
    stepExpect("sync_level_1", 3'b000);
    stepExpect("sync_level_2", 3'b000);
    busA.inSync = 1'b0;
    stepExpect("sync_rel_e1", 3'b000);
    stepExpect("sync_rel_e2", 3'b000);
    stepExpect("sync_rel_e3", 3'b101);

    // Reset and sync together, new ratio 3 taken immediately.
    busA.inDivide = 16'd3;
    busA.inSync = 1'b1;
    resetA = 1'b1;
    stepExpect("rst_sync", 3'b000);
    checkValue("rst_sync_period", {16'd0, busA.outPeriod}, 32'd3);
    busA.inSync = 1'b0;
    resetA = 1'b0;
    stepExpect("n3_e1", 3'b000);
    stepExpect("n3_e2", 3'b101);
    stepExpect("n3_e3", 3'b010);

    // Maximum ratio on the 4-bit instance.
    stepCycle();
    checkValue("max_reset_outs", {29'd0, busB.outClock, busB.outTick, busB.outRise}, 32'd0);
    checkValue("max_period", {28'd0, busB.outPeriod}, 32'd15);
    resetB = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 1; i <= 15; i++) begin
        stepCycle();
        checkValue("max_n15", {29'd0, busB.outClock, busB.outTick, busB.outRise},
                   (i == 15) ? 32'd2 : (i == 8) ? 32'd5 : (i > 8) ? 32'd4 : 32'd0);
      end
    end
    checkValue("max_period_end", {28'd0, busB.outPeriod}, 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
